// File: rtl/valve_sched_pkg.sv
// Shared state encoding and default timing constants for the irrigation valve scheduler.
package valve_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

    localparam int unsigned DEF_TICK_DIV   = 50_000;
    localparam int unsigned DEF_SETTLE_MS  = 500;
    localparam int unsigned DEF_HOLDOFF_MS = 30_000;

endpackage

// File: rtl/valve_sched_ms_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1, tick marks the last count, clr restarts it.
module ms_tick_gen
    import valve_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/valve_sched.sv
// Irrigation valve run scheduler: settle, timed open, settle, holdoff, with stop abort.
module valve_sched
    import valve_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned SETTLE_MS  = DEF_SETTLE_MS,
    parameter int unsigned HOLDOFF_MS = DEF_HOLDOFF_MS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        stop,
    input  logic [15:0] dur_ms,
    output logic        valve_en,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [2:0]  state
);

    state_e      state_q, state_d;
    logic [15:0] ms_q, ms_d;
    logic [15:0] dur_q, dur_d;
    logic        valve_en_q, valve_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        tick, clr, expire;
    logic [15:0] limit;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            ST_OPENING, ST_CLOSING: limit = 16'(SETTLE_MS);
            ST_OPEN:                limit = dur_q;
            ST_HOLDOFF:             limit = 16'(HOLDOFF_MS);
            default:                limit = '0;
        endcase
        // Expire on the last prescaler count of ms number limit-1, i.e. limit*TICK_DIV cycles after entry.
        expire = tick && (({1'b0, ms_q} + 17'd1) == {1'b0, limit});

        case (state_q)
            ST_IDLE: begin
                if (req && (dur_ms != '0)) begin
                    dur_d   = dur_ms;
                    state_d = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (stop) begin
                    state_d   = ST_CLOSING;
                    aborted_d = 1'b1;
                end else if (expire) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (stop) begin
                    state_d   = ST_CLOSING;
                    aborted_d = 1'b1;
                end else if (expire) begin
                    state_d = ST_CLOSING;
                    done_d  = 1'b1;
                end
            end
            ST_CLOSING: if (expire) state_d = ST_HOLDOFF;
            ST_HOLDOFF: if (expire) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        clr        = (state_d != state_q);
        ms_d       = clr ? '0 : (tick ? ms_q + 16'd1 : ms_q);
        valve_en_d = (state_d == ST_OPENING) || (state_d == ST_OPEN);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ms_q       <= '0;
            dur_q      <= '0;
            valve_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_q       <= ms_d;
            dur_q      <= dur_d;
            valve_en_q <= valve_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign valve_en = valve_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign state    = state_q;

endmodule

// File: tb/tb_valve_sched.sv
// Randomized bench for valve_sched against a run-timeline reference model, plus directed scenarios.
module tb_valve_sched;

    localparam int T = 4;
    localparam int S = 2;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] dur_ms = '0;
    logic        valve_en, busy, done, aborted;
    logic [2:0]  state;

    valve_sched #(
        .TICK_DIV  (T),
        .SETTLE_MS (S),
        .HOLDOFF_MS(H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .stop    (stop),
        .dur_ms  (dur_ms),
        .valve_en(valve_en),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .state   (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference: a run is a timeline of absolute cycle indices derived from accept time,
    // captured duration and the cycle closing began (moved earlier by stop).
    int n = 0;
    bit run = 0;
    bit ab = 0;
    int t_acc = 0;
    int c_cyc = 0;
    int ex_st = 0;
    bit ex_done = 0;
    bit ex_ab = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic compute_exp();
        int o, h, i;
        ex_done = 0;
        ex_ab   = 0;
        if (!run) begin
            ex_st = 0;
        end else begin
            o = t_acc + 1 + S * T;
            h = c_cyc + S * T;
            i = h + H * T;
            if (n >= i) begin
                run   = 0;
                ex_st = 0;
            end else if (n >= h) begin
                ex_st = 4;
            end else if (n >= c_cyc) begin
                ex_st = 3;
                if (n == c_cyc) begin
                    ex_ab   = ab;
                    ex_done = !ab;
                end
            end else if (n >= o) begin
                ex_st = 2;
            end else begin
                ex_st = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input int d);
        req    = r;
        stop   = s;
        dur_ms = 16'(d);
        if (ex_st == 0 && r && d != 0) begin
            run   = 1;
            ab    = 0;
            t_acc = n;
            c_cyc = n + 1 + S * T + d * T;
        end else if ((ex_st == 1 || ex_st == 2) && s) begin
            c_cyc = n + 1;
            ab    = 1;
        end
        @(posedge clk);
        #1;
        n++;
        compute_exp();
        chk("state", state, ex_st);
        chk("valve_en", valve_en, int'(ex_st == 1 || ex_st == 2));
        chk("busy", busy, int'(ex_st != 0));
        chk("done", done, int'(ex_done));
        chk("aborted", aborted, int'(ex_ab));
    endtask

    task automatic go_open(input int d);
        for (int i = 0; i < 40 && state != 3'd2; i++) step(0, 0, d);
        chk("reach_open", state, 2);
    endtask

    initial begin
        int ven, bsy, dk, fk, ik;
        bit prev;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_valve", valve_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        rst_n = 1'b1;

        // Normal run, req dropped and dur_ms changed after capture.
        step(1, 0, 5);
        ven = int'(valve_en);
        bsy = int'(busy);
        dk  = done ? 1 : 0;
        for (int k = 2; k <= 60; k++) begin
            step(0, 0, 9);
            if (valve_en) ven++;
            if (busy) bsy++;
            if (done) dk = k;
        end
        chk("norm_open_cycles", ven, 28);
        chk("norm_done_at", dk, 29);
        chk("norm_busy_cycles", bsy, 48);

        // Abort ten cycles into OPEN.
        step(1, 0, 5);
        go_open(5);
        repeat (9) step(0, 0, 5);
        step(0, 1, 5);
        chk("abort_valve", valve_en, 0);
        chk("abort_pulse", aborted, 1);
        chk("abort_nodone", done, 0);
        bsy = int'(busy);
        repeat (30) begin
            step(0, 0, 5);
            if (busy) bsy++;
        end
        chk("abort_to_idle", bsy, 20);

        // Stop on the OPEN expiry cycle.
        step(1, 0, 2);
        go_open(2);
        repeat (7) step(0, 0, 2);
        chk("coinc_still_open", state, 2);
        step(0, 1, 2);
        chk("coinc_aborted", aborted, 1);
        chk("coinc_done", done, 0);
        repeat (25) step(0, 0, 2);

        // req held high: holdoff spacing between runs.
        fk = -1;
        ik = -1;
        prev = 0;
        for (int k = 1; k <= 100 && ik < 0; k++) begin
            step(1, 0, 1);
            if (fk < 0 && prev && !valve_en) fk = k;
            if (fk >= 0 && ik < 0 && state == 3'd0) ik = k;
            prev = valve_en;
        end
        chk("holdoff_gap", ik - fk, 20);
        step(1, 0, 1);
        chk("holdoff_restart", state, 1);
        repeat (50) step(0, 0, 1);

        // Zero duration is never accepted.
        repeat (10) begin
            step(1, 0, 0);
            chk("zero_state", state, 0);
            chk("zero_valve", valve_en, 0);
        end

        // Asynchronous reset during OPEN, then immediate accept after release.
        step(1, 0, 4);
        go_open(4);
        repeat (3) step(0, 0, 4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valve", valve_en, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_busy", busy, 0);
        run   = 0;
        ex_st = 0;
        #1;
        rst_n = 1'b1;
        step(1, 0, 3);
        chk("post_rst_accept", state, 1);

        repeat (3000) begin
            step(($urandom % 4) != 0, ($urandom % 50) == 0, int'($urandom % 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
